// File: rtl/img_pkg.sv
// Shared types for the image stream fetcher: FSM states and per-pixel sideband.
package img_pkg;

   localparam int SB_CH_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic               sof;
      logic               eol;
      logic               eof;
      logic [SB_CH_W-1:0] ch;
   } sideband_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO between the registered ROM read and the output stream.
module fetch_skid_fifo #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign do_pop  = pop && (count != 2'd0);
   assign do_push = push && ((count != 2'd2) || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) mem[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/img_stream_fetch.sv
// Streams a planar CH x WIN x WIN image out of a registered-read ROM as a
// valid/ready pixel stream with plane/row/frame markers.
module img_stream_fetch
   import img_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CH    = 3,
   parameter int ADDR  = 18,
   parameter int WIN   = 256
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic [ADDR-1:0]        rom_addr,
   input  logic [WIDTH-1:0]       rom_data,
   output logic [WIDTH-1:0]       m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic                   m_sof,
   output logic                   m_eol,
   output logic                   m_eof,
   output logic [$clog2(CH)-1:0]  m_ch
);

   localparam int CHW = $clog2(CH);
   localparam int PW  = $clog2(WIN);
   localparam int SBW = $bits(sideband_t);
   localparam logic [PW-1:0]  LAST_POS = PW'(WIN - 1);
   localparam logic [CHW-1:0] LAST_CH  = CHW'(CH - 1);

   if (longint'(CH) * longint'(WIN) * longint'(WIN) > (longint'(1) << ADDR)) begin : g_bad_size
      $error("img_stream_fetch: CH*WIN*WIN does not fit in 2**ADDR");
   end
   if (CHW > SB_CH_W) begin : g_bad_ch
      $error("img_stream_fetch: channel index wider than sideband field");
   end

   fetch_state_e         state;
   logic [PW-1:0]        col;
   logic [PW-1:0]        row;
   logic [CHW-1:0]       ch;
   logic                 inflight;
   sideband_t            cur_sb;
   sideband_t            pipe_sb;
   sideband_t            head_sb;
   logic [WIDTH-1:0]     head_data;
   logic [1:0]           fifo_count;
   logic                 pop;
   logic                 issue;
   logic                 last_pos;

   assign m_valid  = (fifo_count != 2'd0);
   assign pop      = m_valid && m_ready;
   assign done     = pop && head_sb.eof;
   assign busy     = (state != IDLE);
   assign last_pos = (col == LAST_POS) && (row == LAST_POS) && (ch == LAST_CH);

   // Slots already committed (queued + read in flight) must leave room for the
   // new read; a pop this cycle frees one.
   assign issue = (state == RUN) &&
                  ((({1'b0, fifo_count} + {2'b0, inflight}) < 3'd2) || pop);

   always_comb begin
      cur_sb     = '0;
      cur_sb.sof = (col == '0) && (row == '0);
      cur_sb.eol = (col == LAST_POS);
      cur_sb.eof = last_pos;
      cur_sb.ch  = SB_CH_W'(ch);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         col      <= '0;
         row      <= '0;
         ch       <= '0;
         rom_addr <= '0;
         inflight <= 1'b0;
         pipe_sb  <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            pipe_sb <= cur_sb;
            if (last_pos) begin
               col      <= '0;
               row      <= '0;
               ch       <= '0;
               rom_addr <= '0;
            end else begin
               rom_addr <= rom_addr + ADDR'(1);
               if (col == LAST_POS) begin
                  col <= '0;
                  if (row == LAST_POS) begin
                     row <= '0;
                     ch  <= ch + CHW'(1);
                  end else begin
                     row <= row + PW'(1);
                  end
               end else begin
                  col <= col + PW'(1);
               end
            end
         end
         case (state)
            IDLE:    if (start) state <= RUN;
            RUN:     if (issue && last_pos) state <= DRAIN;
            DRAIN:   if (done) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // The ROM registers its output, so the sideband captured at issue lines up
   // with rom_data on the following cycle.
   fetch_skid_fifo #(.W(WIDTH + SBW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight),
      .din   ({rom_data, pipe_sb}),
      .pop   (pop),
      .dout  ({head_data, head_sb}),
      .count (fifo_count)
   );

   assign m_data = head_data;
   assign m_sof  = head_sb.sof;
   assign m_eol  = head_sb.eol;
   assign m_eof  = head_sb.eof;
   assign m_ch   = CHW'(head_sb.ch);

endmodule

// File: tb/tb_img_stream_fetch.sv
// Scoreboard bench for img_stream_fetch on a 3-plane 4x4 image whose ROM word equals its address.
module tb_img_stream_fetch;

   localparam int WIDTH = 16;
   localparam int CH    = 3;
   localparam int ADDR  = 6;
   localparam int WIN   = 4;
   localparam int NPIX  = CH * WIN * WIN;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic             sof;
      logic             eol;
      logic             eof;
      logic [1:0]       ch;
   } beat_t;

   logic             clk;
   logic             rst;
   logic             start;
   logic             busy;
   logic             done;
   logic [ADDR-1:0]  rom_addr;
   logic [WIDTH-1:0] rom_data;
   logic [WIDTH-1:0] m_data;
   logic             m_valid;
   logic             m_ready;
   logic             m_sof;
   logic             m_eol;
   logic             m_eof;
   logic [1:0]       m_ch;

   beat_t sb[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    beats    = 0;
   bit    mon_en   = 1'b1;

   img_stream_fetch #(.WIDTH(WIDTH), .CH(CH), .ADDR(ADDR), .WIN(WIN)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_sof    (m_sof),
      .m_eol    (m_eol),
      .m_eof    (m_eof),
      .m_ch     (m_ch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered-read ROM: word content equals its address.
   always @(posedge clk) rom_data <= WIDTH'(rom_addr);

   // Output monitor: every handshake pops the scoreboard; stalled beats must hold.
   initial begin
      beat_t exp;
      beat_t held;
      bit    held_vld;
      held_vld = 1'b0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            held_vld = 1'b0;
         end else begin
            if (held_vld && m_valid) begin
               n_checks++;
               if ({m_data, m_sof, m_eol, m_eof, m_ch} !==
                   {held.data, held.sof, held.eol, held.eof, held.ch}) begin
                  n_fail++;
                  $display("FAIL stall_hold: data=%0d sof/eol/eof=%b%b%b ch=%0d, held data=%0d sof/eol/eof=%b%b%b ch=%0d",
                           m_data, m_sof, m_eol, m_eof, m_ch, held.data, held.sof, held.eol, held.eof, held.ch);
               end
            end
            if (m_valid && m_ready) begin
               n_checks++;
               if (sb.size() == 0) begin
                  n_fail++;
                  $display("FAIL extra_beat: got data=%0d, expected no beat", m_data);
               end else begin
                  exp = sb.pop_front();
                  if ({m_data, m_sof, m_eol, m_eof, m_ch, done} !==
                      {exp.data, exp.sof, exp.eol, exp.eof, exp.ch, exp.eof}) begin
                     n_fail++;
                     $display("FAIL beat: got data=%0d sof/eol/eof=%b%b%b ch=%0d done=%b, expected data=%0d sof/eol/eof=%b%b%b ch=%0d done=%b",
                              m_data, m_sof, m_eol, m_eof, m_ch, done,
                              exp.data, exp.sof, exp.eol, exp.eof, exp.ch, exp.eof);
                  end
               end
               beats++;
               held_vld = 1'b0;
            end else begin
               n_checks++;
               if (done !== 1'b0) begin
                  n_fail++;
                  $display("FAIL done_no_handshake: done=%b, expected 0", done);
               end
               held_vld  = m_valid;
               held.data = m_data;
               held.sof  = m_sof;
               held.eol  = m_eol;
               held.eof  = m_eof;
               held.ch   = m_ch;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic push_frame();
      beat_t b;
      for (int i = 0; i < NPIX; i++) begin
         b.data = WIDTH'(i);
         b.ch   = 2'(i / (WIN * WIN));
         b.sof  = (i % (WIN * WIN)) == 0;
         b.eol  = (i % WIN) == WIN - 1;
         b.eof  = (i == NPIX - 1);
         sb.push_back(b);
      end
   endtask

   // Leaves the bench #1 after the edge E0 at which start was sampled.
   task automatic pulse_start();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_drain(input int pct, input int budget, output int cycles);
      cycles = 0;
      while (sb.size() != 0 && cycles < budget) begin
         @(posedge clk); #1;
         m_ready = ($urandom_range(99) < pct);
         cycles++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({busy, done, m_valid} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_ctrl: busy/done/m_valid=%b, expected 000", {busy, done, m_valid});
      end
      n_checks++;
      if (rom_addr !== '0) begin
         n_fail++;
         $display("FAIL reset_addr: rom_addr=%0d, expected 0", rom_addr);
      end
      n_checks++;
      if ({m_data, m_ch, m_sof, m_eol, m_eof} !== '0) begin
         n_fail++;
         $display("FAIL reset_stream: data=%0d ch=%0d sof/eol/eof=%b%b%b, expected all 0",
                  m_data, m_ch, m_sof, m_eol, m_eof);
      end
      rst = 1'b0;
   endtask

   task automatic test_full_rate();
      int cyc;
      m_ready = 1'b1;
      push_frame();
      pulse_start();
      n_checks++;
      if (rom_addr !== 6'd0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL full_e0: rom_addr=%0d busy=%b, expected 0 1", rom_addr, busy);
      end
      @(posedge clk); #1;
      n_checks++;
      if (m_valid !== 1'b0 || rom_addr !== 6'd1) begin
         n_fail++;
         $display("FAIL full_e1: m_valid=%b rom_addr=%0d, expected 0 1", m_valid, rom_addr);
      end
      @(posedge clk); #1;
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 16'd0) begin
         n_fail++;
         $display("FAIL full_e2: m_valid=%b m_data=%0d, expected 1 0", m_valid, m_data);
      end
      wait_drain(100, 200, cyc);
      n_checks++;
      if (cyc != NPIX || sb.size() != 0) begin
         n_fail++;
         $display("FAIL full_rate: %0d cycles with %0d left, expected %0d cycles with 0 left", cyc, sb.size(), NPIX);
      end
      n_checks++;
      if (busy !== 1'b0 || m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL full_idle: busy=%b m_valid=%b, expected 0 0", busy, m_valid);
      end
   endtask

   task automatic test_random_ready();
      int cyc;
      m_ready = 1'b0;
      push_frame();
      pulse_start();
      wait_drain(30, 3000, cyc);
      n_checks++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL random_ready: %0d beats left busy=%b, expected 0 left busy=0", sb.size(), busy);
      end
   endtask

   task automatic test_stall();
      int cyc;
      m_ready = 1'b0;
      push_frame();
      pulse_start();
      // Addresses 0 and 1 fill the FIFO; address 2 stays presented but unread.
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (i >= 2) begin
            n_checks++;
            if (rom_addr !== 6'd2 || m_valid !== 1'b1 || m_data !== 16'd0) begin
               n_fail++;
               $display("FAIL stall_cycle%0d: rom_addr=%0d m_valid=%b m_data=%0d, expected 2 1 0",
                        i, rom_addr, m_valid, m_data);
            end
         end
      end
      wait_drain(100, 200, cyc);
      n_checks++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_resume: %0d beats left busy=%b, expected 0 left busy=0", sb.size(), busy);
      end
   endtask

   task automatic test_start_ignored();
      int cyc;
      m_ready = 1'b0;
      push_frame();
      pulse_start();
      wait_drain(50, 15, cyc);
      pulse_start();
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_busy: busy=%b, expected 1", busy);
      end
      wait_drain(50, 3000, cyc);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL restart_drain: %0d beats left, expected 0", sb.size());
      end
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (m_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_tail%0d: m_valid=%b busy=%b, expected 0 0", i, m_valid, busy);
         end
      end
   endtask

   task automatic test_mid_reset();
      int n;
      int b0;
      int cyc;
      b0 = beats;
      m_ready = 1'b1;
      push_frame();
      pulse_start();
      n = 0;
      while (beats < b0 + 20 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      n_checks++;
      if (beats != b0 + 20) begin
         n_fail++;
         $display("FAIL midrst_reach: %0d beats, expected 20", beats - b0);
      end
      mon_en = 1'b0;
      sb.delete();
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0 || rom_addr !== 6'd0 || m_data !== 16'd0) begin
         n_fail++;
         $display("FAIL midrst_clear: m_valid=%b busy=%b rom_addr=%0d m_data=%0d, expected 0 0 0 0",
                  m_valid, busy, rom_addr, m_data);
      end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_quiet%0d: m_valid=%b, expected 0", i, m_valid);
         end
      end
      mon_en = 1'b1;
      push_frame();
      pulse_start();
      wait_drain(100, 200, cyc);
      n_checks++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_restart: %0d beats left busy=%b, expected 0 left busy=0", sb.size(), busy);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      int cyc;
      m_ready = 1'b1;
      push_frame();
      push_frame();
      pulse_start();
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (done !== 1'b1 && n < 200);
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_done: done not seen in %0d cycles, expected pulse", n);
      end
      pulse_start();
      n_checks++;
      if (busy !== 1'b1 || rom_addr !== 6'd0) begin
         n_fail++;
         $display("FAIL b2b_accept: busy=%b rom_addr=%0d, expected 1 0", busy, rom_addr);
      end
      @(posedge clk); #1;
      n_checks++;
      if (rom_addr !== 6'd1) begin
         n_fail++;
         $display("FAIL b2b_issue: rom_addr=%0d, expected 1", rom_addr);
      end
      wait_drain(100, 200, cyc);
      n_checks++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_drain: %0d beats left busy=%b, expected 0 left busy=0", sb.size(), busy);
      end
   endtask

   initial begin
      test_reset();
      test_full_rate();
      test_random_ready();
      test_stall();
      test_start_ignored();
      test_mid_reset();
      test_back_to_back();
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
